// File: rtl/dcache_pkg.sv
// Shared definitions for the M-stage data cache: FSM states, funct3 access encodings
// and the byte-merge helper used when a store hits a resident line.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} dcache_state_e;

  localparam int ADDR_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_lane_align.sv
// Byte-lane steering: store strobes/data placement and load lane extract with extension.
// Sub-size address bits below the access size are ignored, so misaligned accesses never trap.
module dcache_lane_align
  import dcache_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = load_word_i[{addr_lo_i, 3'b000} +: 8];
  assign ld_half = load_word_i[{addr_lo_i[1], 4'b0000} +: 16];

  // Store size only depends on funct3[1:0]; the unsigned bit has no meaning for stores.
  always_comb begin
    wstrb_o = 4'hF;
    wdata_o = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {24'd0, store_data_i[7:0]} << {addr_lo_i, 3'b000};
      end
      2'b01: begin
        wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {16'd0, store_data_i[15:0]} << {addr_lo_i[1], 4'b0000};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (funct3_i)
      F3_B:    load_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    load_data_o = {{16{ld_half[15]}}, ld_half};
      F3_BU:   load_data_o = {24'd0, ld_byte};
      F3_HU:   load_data_o = {16'd0, ld_half};
      F3_W:    load_data_o = load_word_i;
      default: load_data_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache serving the pipeline M stage.
// Define DCACHE_PERF_EN to add the HitCount/MissCount performance counter outputs.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  AddressingControlM,
  output logic [31:0] RDM,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
`endif
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  dcache_state_e state_q, state_d;
  logic [WORD_W-1:0] wcnt_q, wcnt_d;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_arr  [SETS];
  logic [31:0]       data_arr [SETS*LINE_WORDS];

  logic [TAG_W-1:0]  addr_tag;
  logic [IDX_W-1:0]  addr_idx;
  logic [WORD_W-1:0] addr_word;
  logic              hit, last_word;
  logic [31:0]       cached_word, ld_data, st_wdata;
  logic [3:0]        st_strb;

  assign addr_tag    = ALUResultM[ADDR_W-1 -: TAG_W];
  assign addr_idx    = ALUResultM[OFF_W +: IDX_W];
  assign addr_word   = ALUResultM[2 +: WORD_W];
  assign hit         = valid_q[addr_idx] && (tag_arr[addr_idx] == addr_tag);
  assign cached_word = data_arr[{addr_idx, addr_word}];
  assign last_word   = (wcnt_q == WORD_W'(LINE_WORDS - 1));
  assign RDM         = hit ? ld_data : 32'd0;

  dcache_lane_align u_align (
    .addr_lo_i   (ALUResultM[1:0]),
    .funct3_i    (AddressingControlM),
    .store_data_i(WriteDataM),
    .load_word_i (cached_word),
    .wstrb_o     (st_strb),
    .wdata_o     (st_wdata),
    .load_data_o (ld_data)
  );

  // Stores release the pipe in their ack cycle so the held store is not re-issued from IDLE.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    StallM    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    case (state_q)
      IDLE: begin
        wcnt_d = '0;
        if (MemWriteM) begin
          state_d = WRITE;
          StallM  = 1'b1;
        end else if (MemReadM && !hit) begin
          state_d = REFILL;
          StallM  = 1'b1;
        end
      end
      REFILL: begin
        StallM   = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {ALUResultM[ADDR_W-1:OFF_W], wcnt_q, 2'b00};
        if (mem_ack) begin
          wcnt_d = wcnt_q + WORD_W'(1);
          if (last_word) state_d = RESP;
        end
      end
      WRITE: begin
        StallM    = !mem_ack;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {ALUResultM[31:2], 2'b00};
        mem_wdata = st_wdata;
        mem_wstrb = st_strb;
        if (mem_ack) state_d = IDLE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!rst) StallM = 1'b0;
  end

  // A line only becomes valid with its last refill word, so an aborted refill stays invisible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_q == REFILL && mem_ack && last_word) valid_q[addr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == REFILL && mem_ack) begin
      data_arr[{addr_idx, wcnt_q}] <= mem_rdata;
      if (last_word) tag_arr[addr_idx] <= addr_tag;
    end else if (state_q == WRITE && mem_ack && hit) begin
      data_arr[{addr_idx, addr_word}] <= byte_merge(cached_word, st_wdata, st_strb);
    end
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if ((state_q == IDLE && MemReadM && !MemWriteM && hit) ||
          (state_q == WRITE && mem_ack && hit))
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == RESP || (state_q == WRITE && mem_ack && !hit))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: table of load/store transactions against a word-wide
// memory model (2-cycle ack delay), plus reset checks and a reset-during-refill sequence.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUResultM = 32'd0;
  logic [31:0] WriteDataM = 32'd0;
  logic [2:0]  AddressingControlM = 3'b010;
  logic [31:0] RDM;
  logic        StallM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
`ifdef DCACHE_PERF_EN
  logic [31:0] HitCount, MissCount;
`endif

  dcache_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .MemReadM          (MemReadM),
    .MemWriteM         (MemWriteM),
    .ALUResultM        (ALUResultM),
    .WriteDataM        (WriteDataM),
    .AddressingControlM(AddressingControlM),
    .RDM               (RDM),
    .StallM            (StallM),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_wstrb         (mem_wstrb),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack)
`ifdef DCACHE_PERF_EN
    ,
    .HitCount          (HitCount),
    .MissCount         (MissCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, expRdm;
    int          expStall, expReads, expWrites;
    logic [31:0] expWaddr, expWdata;
    logic [3:0]  expWstrb;
  } vec_t;

  int testsRun = 0;
  int failures = 0;

  // Memory model: unwritten word at A reads as {A[15:0], ~A[15:0]}.
  logic [31:0] memArr [logic [31:0]];
  logic [31:0] readAddrQ [$];
  int          memLat = 2;
  int          waitCnt = 0;
  int          readAcks = 0, writeAcks = 0, reqCycles = 0;
  logic [31:0] lastWaddr = 32'd0, lastWdata = 32'd0;
  logic [3:0]  lastWstrb = 4'd0;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    #2;
    if (mem_req) reqCycles++;
    if (!rst) begin
      mem_ack = 1'b0;
      waitCnt = 0;
    end else if (mem_req && waitCnt == memLat) begin
      mem_ack = 1'b1;
      waitCnt = 0;
      if (mem_we) begin
        w = memRead(mem_addr);
        for (int i = 0; i < 4; i++) if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
        memArr[mem_addr] = w;
        lastWaddr = mem_addr;
        lastWdata = mem_wdata;
        lastWstrb = mem_wstrb;
        writeAcks++;
      end else begin
        mem_rdata = memRead(mem_addr);
        readAddrQ.push_back(mem_addr);
        readAcks++;
      end
    end else begin
      mem_ack = 1'b0;
      waitCnt = mem_req ? waitCnt + 1 : 0;
    end
  end

  task automatic checkValue(input string what, input int id, input logic [31:0] act,
                            input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s vec%0d: got 0x%08h, expected 0x%08h", what, id, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdm, input int stall, input int reads,
                                 input int writes, input logic [31:0] waddr,
                                 input logic [31:0] wd, input logic [3:0] strb);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.expRdm = expRdm;
    v.expStall = stall; v.expReads = reads; v.expWrites = writes;
    v.expWaddr = waddr; v.expWdata = wd; v.expWstrb = strb;
    return v;
  endfunction

  // Runs one access until StallM drops (bounded), then releases the request.
  task automatic applyStimulus(input vec_t v, output logic [31:0] rdm, output int stall,
                               output int reads, output int writes, output int reqs,
                               output bit timedOut);
    int r0, w0, q0;
    @(posedge clk); #1;
    r0 = readAcks; w0 = writeAcks; q0 = reqCycles;
    readAddrQ.delete();
    MemReadM = v.rd; MemWriteM = v.wr; AddressingControlM = v.f3;
    ALUResultM = v.addr; WriteDataM = v.wdata;
    stall = 0; timedOut = 1'b1; rdm = 32'd0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (StallM) stall++;
      else begin
        rdm = RDM;
        timedOut = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    MemReadM = 1'b0; MemWriteM = 1'b0;
    reads = readAcks - r0; writes = writeAcks - w0; reqs = reqCycles - q0;
  endtask

  task automatic checkOutput(input int id, input vec_t v, input logic [31:0] rdm, input int stall,
                             input int reads, input int writes, input int reqs, input bit timedOut);
    logic [31:0] got;
    checkValue("timeout", id, 32'(timedOut), 32'd0);
    checkValue("stall_cycles", id, stall, v.expStall);
    checkValue("mem_reads", id, reads, v.expReads);
    checkValue("mem_writes", id, writes, v.expWrites);
    if (v.rd && !v.wr) checkValue("rdm", id, rdm, v.expRdm);
    if (v.expStall == 0) checkValue("req_cycles", id, reqs, 0);
    if (v.expWrites > 0) begin
      checkValue("waddr", id, lastWaddr, v.expWaddr);
      checkValue("wdata", id, lastWdata, v.expWdata);
      checkValue("wstrb", id, 32'(lastWstrb), 32'(v.expWstrb));
    end
    for (int i = 0; i < v.expReads; i++) begin
      got = (i < readAddrQ.size()) ? readAddrQ[i] : 32'hFFFF_FFFF;
      checkValue("refill_addr", id, got, {v.addr[31:4], 4'h0} + 32'(4 * i));
    end
  endtask

  vec_t        vecs [22];
  vec_t        v6;
  logic [31:0] rdm;
  int          stall, reads, writes, reqs, r0;
  bit          timedOut, seen;

  initial begin
    vecs[0]  = mkVec(1, 0, 3'b010, 32'h100,  0,            32'h0100FEFF, 13, 4, 0, 0, 0, 0);
    vecs[1]  = mkVec(1, 0, 3'b010, 32'h104,  0,            32'h0104FEFB, 0,  0, 0, 0, 0, 0);
    vecs[2]  = mkVec(0, 1, 3'b000, 32'h105,  32'h12345680, 0, 3, 0, 1, 32'h104, 32'h00008000, 4'b0010);
    vecs[3]  = mkVec(1, 0, 3'b000, 32'h105,  0,            32'hFFFFFF80, 0,  0, 0, 0, 0, 0);
    vecs[4]  = mkVec(1, 0, 3'b100, 32'h105,  0,            32'h00000080, 0,  0, 0, 0, 0, 0);
    vecs[5]  = mkVec(1, 0, 3'b001, 32'h104,  0,            32'hFFFF80FB, 0,  0, 0, 0, 0, 0);
    vecs[6]  = mkVec(1, 0, 3'b101, 32'h106,  0,            32'h00000104, 0,  0, 0, 0, 0, 0);
    vecs[7]  = mkVec(1, 0, 3'b001, 32'h105,  0,            32'hFFFF80FB, 0,  0, 0, 0, 0, 0);
    vecs[8]  = mkVec(0, 1, 3'b010, 32'h2000, 32'hDEADBEEF, 0, 3, 0, 1, 32'h2000, 32'hDEADBEEF, 4'hF);
    vecs[9]  = mkVec(1, 0, 3'b010, 32'h2000, 0,            32'hDEADBEEF, 13, 4, 0, 0, 0, 0);
    vecs[10] = mkVec(1, 0, 3'b010, 32'h2004, 0,            32'h2004DFFB, 0,  0, 0, 0, 0, 0);
    vecs[11] = mkVec(1, 0, 3'b010, 32'h1100, 0,            32'h1100EEFF, 13, 4, 0, 0, 0, 0);
    vecs[12] = mkVec(1, 0, 3'b010, 32'h100,  0,            32'h0100FEFF, 13, 4, 0, 0, 0, 0);
    vecs[13] = mkVec(1, 0, 3'b010, 32'h104,  0,            32'h010480FB, 0,  0, 0, 0, 0, 0);
    vecs[14] = mkVec(0, 1, 3'b001, 32'h10A,  32'h0000BEEF, 0, 3, 0, 1, 32'h108, 32'hBEEF0000, 4'b1100);
    vecs[15] = mkVec(1, 0, 3'b010, 32'h108,  0,            32'hBEEFFEF7, 0,  0, 0, 0, 0, 0);
    vecs[16] = mkVec(1, 1, 3'b010, 32'h10C,  32'h11223344, 0, 3, 0, 1, 32'h10C, 32'h11223344, 4'hF);
    vecs[17] = mkVec(1, 0, 3'b010, 32'h10C,  0,            32'h11223344, 0,  0, 0, 0, 0, 0);
    vecs[18] = mkVec(1, 0, 3'b100, 32'h10F,  0,            32'h00000011, 0,  0, 0, 0, 0, 0);
    vecs[19] = mkVec(1, 0, 3'b000, 32'h10C,  0,            32'h00000044, 0,  0, 0, 0, 0, 0);
    vecs[20] = mkVec(0, 1, 3'b010, 32'h10E,  32'hCAFEF00D, 0, 3, 0, 1, 32'h10C, 32'hCAFEF00D, 4'hF);
    vecs[21] = mkVec(1, 0, 3'b010, 32'h10C,  0,            32'hCAFEF00D, 0,  0, 0, 0, 0, 0);

    // In reset with a load presented: everything quiet, no hit.
    MemReadM = 1'b1; ALUResultM = 32'h100;
    #7;
    checkValue("rst_stall", -1, 32'(StallM), 0);
    checkValue("rst_req", -1, 32'(mem_req), 0);
    checkValue("rst_we", -1, 32'(mem_we), 0);
    checkValue("rst_addr", -1, mem_addr, 0);
    checkValue("rst_wdata", -1, mem_wdata, 0);
    checkValue("rst_wstrb", -1, 32'(mem_wstrb), 0);
    checkValue("rst_rdm", -1, RDM, 0);
    MemReadM = 1'b0;
    #14 rst = 1'b1;
    @(negedge clk);
    checkValue("idle_stall", -1, 32'(StallM), 0);
    checkValue("idle_req", -1, 32'(mem_req), 0);

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i], rdm, stall, reads, writes, reqs, timedOut);
      checkOutput(i, vecs[i], rdm, stall, reads, writes, reqs, timedOut);
    end

    // Reset while the third refill word is outstanding.
    v6 = mkVec(1, 0, 3'b010, 32'h300, 0, 32'h0300FCFF, 13, 4, 0, 0, 0, 0);
    @(posedge clk); #1;
    r0 = readAcks;
    MemReadM = 1'b1; MemWriteM = 1'b0; AddressingControlM = 3'b010; ALUResultM = 32'h300;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (readAcks - r0 == 2) begin
        seen = 1'b1;
        break;
      end
    end
    checkValue("abort_two_words", 100, 32'(seen), 1);
    @(negedge clk);
    checkValue("abort_req_word2", 100, 32'(mem_req), 1);
    checkValue("abort_addr_word2", 100, mem_addr, 32'h308);
    #1 rst = 1'b0;
    #1;
    checkValue("abort_req_drop", 100, 32'(mem_req), 0);
    checkValue("abort_stall_drop", 100, 32'(StallM), 0);
    MemReadM = 1'b0;
    @(posedge clk); #1;
    checkValue("abort_req_edge", 100, 32'(mem_req), 0);
    @(posedge clk); #1 rst = 1'b1;
    applyStimulus(v6, rdm, stall, reads, writes, reqs, timedOut);
    checkOutput(101, v6, rdm, stall, reads, writes, reqs, timedOut);
    v6 = mkVec(1, 0, 3'b010, 32'h104, 0, 32'h010480FB, 13, 4, 0, 0, 0, 0);
    applyStimulus(v6, rdm, stall, reads, writes, reqs, timedOut);
    checkOutput(102, v6, rdm, stall, reads, writes, reqs, timedOut);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
